// File: rtl/rv_pipe_pkg.sv
// Shared RV32I pipeline constants: stage indices for the forwarding network and
// the default register address width.
package rv_pipe_pkg;

  localparam int STG_EX = 0;
  localparam int STG_MA = 1;
  localparam int STG_WB = 2;
  localparam int AW_DEF = 5;

  // Width of a stage index, never narrower than one bit.
  function automatic int stg_w(input int nstg);
    return (nstg > 1) ? $clog2(nstg) : 1;
  endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Per-source priority match: one-hot youngest forwardable producer, a
// register-file fallback flag, and the stage of the youngest unready load.
module fwd_src_sel
  import rv_pipe_pkg::*;
#(
  parameter int NSTG   = STG_WB + 1,
  parameter int AW     = AW_DEF,
  parameter int LD_RDY = STG_MA,
  localparam int SW    = stg_w(NSTG)
) (
  input  logic [AW-1:0]      rs,
  input  logic               rs_valid,
  input  logic [NSTG*AW-1:0] rd_adr_stg,
  input  logic [NSTG-1:0]    wbk_stg,
  input  logic [NSTG-1:0]    ld_stg,
  input  logic [NSTG-1:0]    stall_stg,
  input  logic [NSTG-1:0]    bubble_mask,
  output logic [NSTG-1:0]    sel,
  output logic               nohit,
  output logic               hz,
  output logic [SW-1:0]      hz_stg
);

  logic [NSTG-1:0] match;
  logic [NSTG-1:0] early_ld;
  logic            found;

  for (genvar s = 0; s < NSTG; s++) begin : g_match
    // x0 is hardwired zero, so a zero destination never matches.
    assign match[s] = rs_valid && (rd_adr_stg[s*AW +: AW] != '0) &&
                      (rd_adr_stg[s*AW +: AW] == rs) && wbk_stg[s] &&
                      !stall_stg[s] && !bubble_mask[s];
    assign early_ld[s] = ld_stg[s] && (s < LD_RDY);
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    sel    = '0;
    found  = 1'b0;
    hz     = 1'b0;
    hz_stg = '0;
    for (int s = 0; s < NSTG; s++) begin
      if (match[s] && early_ld[s] && !hz) begin
        hz     = 1'b1;
        hz_stg = SW'(s);
      end
      if (match[s] && !early_ld[s] && !found) begin
        sel[s] = 1'b1;
        found  = 1'b1;
      end
    end
    // A pending load wins: the operand is re-evaluated once the bubbles drain.
    if (hz) sel = '0;
    nohit = !found && !hz;
  end

endmodule

// File: rtl/fwd_hazard_unit_n.sv
// Forwarding and load-use hazard unit: registers per-source forward selects
// into EX and stretches load-use bubbles until load data is forwardable.
module fwd_hazard_unit_n
  import rv_pipe_pkg::*;
#(
  parameter int NSRC   = 2,
  parameter int NSTG   = STG_WB + 1,
  parameter int AW     = AW_DEF,
  parameter int LD_RDY = STG_MA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rst_pipe,
  input  logic                 stall,
  input  logic                 use_collision_add,
  input  logic [NSRC*AW-1:0]   rs_id,
  input  logic [NSRC-1:0]      rs_valid,
  input  logic [NSTG*AW-1:0]   rd_adr_stg,
  input  logic [NSTG-1:0]      wbk_stg,
  input  logic [NSTG-1:0]      ld_stg,
  input  logic [NSTG-1:0]      stall_stg,
  output logic [NSRC*NSTG-1:0] hit_sel_ex,
  output logic [NSRC-1:0]      nohit_ex,
  output logic                 stall_ld,
  output logic                 stall_ld_ex,
  output logic [1:0]           bubble_cnt
);

  localparam int SW = stg_w(NSTG);

  logic [NSRC*NSTG-1:0] sel;
  logic [NSRC-1:0]      nohit;
  logic [NSRC-1:0]      hz;
  logic [SW-1:0]        hz_stg [NSRC];
  logic [NSTG-1:0]      bubble_mask;
  logic [NSTG-1:0]      mask_nxt;
  logic                 hz_any;
  logic [1:0]           ld_cnt;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    fwd_src_sel #(
      .NSTG   (NSTG),
      .AW     (AW),
      .LD_RDY (LD_RDY)
    ) u_sel (
      .rs          (rs_id[k*AW +: AW]),
      .rs_valid    (rs_valid[k]),
      .rd_adr_stg  (rd_adr_stg),
      .wbk_stg     (wbk_stg),
      .ld_stg      (ld_stg),
      .stall_stg   (stall_stg),
      .bubble_mask (bubble_mask),
      .sel         (sel[k*NSTG +: NSTG]),
      .nohit       (nohit[k]),
      .hz          (hz[k]),
      .hz_stg      (hz_stg[k])
    );
  end

  // The nearest unready load across all sources sets the bubble count.
  always_comb begin
    hz_any = 1'b0;
    ld_cnt = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (hz[k]) begin
        hz_any = 1'b1;
        if (2'(LD_RDY - 1 - int'(hz_stg[k])) > ld_cnt)
          ld_cnt = 2'(LD_RDY - 1 - int'(hz_stg[k]));
      end
    end
  end

  assign stall_ld = hz_any || (bubble_cnt != 2'd0) || use_collision_add;

  always_comb begin
    mask_nxt         = bubble_mask << 1;
    mask_nxt[STG_EX] = stall_ld;
  end

  // NOTE: asynchronous reset covers every flop here; these are small control
  // registers, not a memory array, so none are left uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_sel_ex  <= '0;
      nohit_ex    <= '0;
      stall_ld_ex <= 1'b0;
      bubble_mask <= '0;
      bubble_cnt  <= '0;
    end else if (rst_pipe) begin
      hit_sel_ex  <= '0;
      nohit_ex    <= '0;
      stall_ld_ex <= 1'b0;
      bubble_mask <= '0;
      bubble_cnt  <= '0;
    end else if (!stall) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      hit_sel_ex  <= sel;
      nohit_ex    <= nohit;
      stall_ld_ex <= stall_ld;
      bubble_mask <= mask_nxt;
      if (bubble_cnt != 2'd0) bubble_cnt <= bubble_cnt - 2'd1;
      else if (hz_any)        bubble_cnt <= ld_cnt;
    end
  end

endmodule
